// File: rtl/imm_pkg.sv
// Shared types and the immediate-extension function for imm_extender_pipe.
// Optional feature macro: IMM_ZIMM_EN (immsrc=101 selects the CSR zimm format).
package imm_pkg;

  // Widest supported datapath. The extension is always done at this width,
  // and narrower builds keep only the low XLEN bits.
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4,
    IMM_Z = 3'd5
  } imm_src_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Returns {illegal, value}. An illegal encoding yields value 0 so the beat
  // can still travel to the trap logic in order.
  function automatic logic [MAX_XLEN:0] imm_extend(input logic [31:7] instr,
                                                   input logic [2:0]  immsrc);
    logic signed [MAX_XLEN-1:0] value;
    logic                       illegal;
    logic                       sgn;
    sgn     = instr[31];
    value   = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I: value = {{52{sgn}}, instr[31:20]};
      IMM_S: value = {{52{sgn}}, instr[31:25], instr[11:7]};
      IMM_B: value = {{52{sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: value = {{44{sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: value = {{32{sgn}}, instr[31:12], 12'b0};
`ifdef IMM_ZIMM_EN
      IMM_Z: value = {59'b0, instr[19:15]};
`else
      IMM_Z: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
    return {illegal, value};
  endfunction

endpackage

// File: rtl/imm_extender_pipe_if.sv
// Decode-side and execute-side handshake bundle of imm_extender_pipe.
// master = the surrounding pipeline, slave = the extender itself.
interface imm_extender_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:7]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immext;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, immsrc, in_tag, out_ready,
    input  in_ready, out_valid, immext, out_tag, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, immsrc, in_tag, out_ready,
    output in_ready, out_valid, immext, out_tag, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready slice. in_ready and out_valid are both
// registered, so there is no combinational path from out_ready to in_ready.
module imm_skid_buf
  import imm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state;
  logic [DATA_W-1:0] main_p1;
  logic [DATA_W-1:0] skid_p1;
  logic              in_acc;
  logic              out_acc;

  assign in_acc   = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;
  assign out_data = main_p1;

  // Occupancy FSM: main feeds the outputs, skid absorbs the one beat that
  // arrives while downstream stalls; flush empties without touching data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_p1   <= '0;
      skid_p1   <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            main_p1   <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_p1 <= in_data;
          end else if (in_acc) begin
            skid_p1  <= in_data;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_acc) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_acc) begin
            main_p1  <= skid_p1;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_extender_pipe.sv
// Registered RV32/RV64 immediate extender with a 2-entry skid buffer and a
// saturating counter of accepted illegal immsrc beats.
// Optional feature macro: IMM_ZIMM_EN (immsrc=101 -> zero-extended instr[19:15]).
module imm_extender_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  imm_extender_pipe_if.slave bus
);

  localparam int PAY_W = 1 + TAG_W + XLEN;

  logic [MAX_XLEN:0] ext_p0;
  logic              ill_p0;
  logic [XLEN-1:0]   imm_p0;
  logic [PAY_W-1:0]  pay_p0;
  logic [PAY_W-1:0]  pay_p1;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- stage p0: combinational extension of the presented beat ----
  assign ext_p0 = imm_extend(bus.instr, bus.immsrc);
  assign ill_p0 = ext_p0[MAX_XLEN];
  assign imm_p0 = XLEN'(ext_p0[MAX_XLEN-1:0]);
  assign pay_p0 = {ill_p0, bus.in_tag, imm_p0};

  imm_skid_buf #(
    .DATA_W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (pay_p0),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (pay_p1)
  );

  // ---- stage p1: registered outputs ----
  assign {bus.out_illegal, bus.out_tag, bus.immext} = pay_p1;
  assign bus.illegal_cnt = cnt_q;

  assign cnt_en = bus.in_valid & bus.in_ready & ~flush & ill_p0;

  // Count illegal beats at acceptance; flushed beats are never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Bench for imm_extender_pipe: an XLEN=32/CNT_W=2 and an XLEN=64/CNT_W=8
// instance share one stimulus stream and are checked against a queue model.
module tb_imm_extender_pipe;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [24:0]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;

  int vectors = 0;
  int errs    = 0;
  int cnt32   = 0;
  int cnt64   = 0;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } beat_t;
  beat_t mq[$];

  imm_extender_pipe_if #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(2)) bus32 ();
  imm_extender_pipe_if #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(8)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.instr     = instr;
  assign bus32.immsrc    = immsrc;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.instr     = instr;
  assign bus64.immsrc    = immsrc;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  imm_extender_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus32.slave)
  );
  imm_extender_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus64.slave)
  );

  always #5 clk = ~clk;

  // Reference: rebuild the full instruction word and pull the immediate out
  // with 64-bit arithmetic. Returns {illegal, value}.
  function automatic logic [64:0] ref_imm(input logic [24:0] f, input logic [2:0] src);
    logic signed [31:0] iw;
    longint w;
    longint r;
    logic   ill;
    iw  = {f, 7'b0};
    w   = iw;
    r   = 0;
    ill = 1'b0;
    case (src)
      3'd0: r = w >>> 20;
      3'd1: r = ((w >>> 25) <<< 5) | ((w >> 7) & 31);
      3'd2: r = ((w >>> 31) <<< 12) | (((w >> 7) & 1) <<< 11)
              | (((w >> 25) & 63) <<< 5) | (((w >> 8) & 15) <<< 1);
      3'd3: r = ((w >>> 31) <<< 20) | (((w >> 12) & 255) <<< 12)
              | (((w >> 20) & 1) <<< 11) | (((w >> 21) & 1023) <<< 1);
      3'd4: r = w & ~longint'(4095);
`ifdef IMM_ZIMM_EN
      3'd5: r = (w >> 15) & 31;
`else
      3'd5: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
    if (ill) r = 0;
    return {ill, r};
  endfunction

  // One clock: update the model with what the DUTs see at the edge, then
  // step 1 time unit past the edge for sampling.
  task automatic cycle();
    logic        acc_in;
    logic        acc_out;
    logic [64:0] r;
    beat_t       b;
    @(posedge clk);
    acc_in  = in_valid && (mq.size() < 2);
    acc_out = out_ready && (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (acc_out) void'(mq.pop_front());
      if (acc_in) begin
        r     = ref_imm(instr, immsrc);
        b.imm = r[63:0];
        b.tag = in_tag;
        b.ill = r[64];
        mq.push_back(b);
        if (r[64]) begin
          if (cnt32 < 3)   cnt32++;
          if (cnt64 < 255) cnt64++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; immsrc = '0; in_tag = '0;
    #12;
    vectors++;
    if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0 || bus32.immext !== 32'h0 ||
        bus64.immext !== 64'h0 || bus32.out_tag !== '0 || bus64.out_tag !== '0 ||
        bus32.out_illegal !== 1'b0 || bus64.out_illegal !== 1'b0 ||
        bus32.illegal_cnt !== 2'd0 || bus64.illegal_cnt !== 8'd0) begin
      errs++;
      $display("FAIL reset_outputs: got vld=%b/%b imm=%h/%h tag=%h/%h ill=%b/%b cnt=%0d/%0d want all zero",
               bus32.out_valid, bus64.out_valid, bus32.immext, bus64.immext, bus32.out_tag,
               bus64.out_tag, bus32.out_illegal, bus64.out_illegal, bus32.illegal_cnt, bus64.illegal_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); cnt32 = 0; cnt64 = 0;
    cycle();
    vectors++;
    if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1 ||
        bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got rdy=%b/%b vld=%b/%b want rdy=1 vld=0",
               bus32.in_ready, bus64.in_ready, bus32.out_valid, bus64.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [24:0] f_t [4];
    logic [2:0]  s_t [4];
    logic [63:0] e_t [4];
    f_t = '{{12'hFFC, 13'h0}, 25'b1_111111_00000_00000_000_0010_0,
            25'b0_0000000100_1_00110000_00000, {20'hFFF00, 5'h0}};
    s_t = '{3'd0, 3'd2, 3'd3, 3'd4};
    e_t = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_F7E4,
            64'h0000_0000_0003_0808, 64'hFFFF_FFFF_FFF0_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = f_t[i]; immsrc = s_t[i]; in_tag = TAG_W'(i + 4);
      cycle();
      vectors++;
      if (bus32.out_valid !== 1'b1 || bus64.out_valid !== 1'b1 ||
          bus32.immext !== e_t[i][31:0] || bus64.immext !== e_t[i] ||
          bus32.out_illegal !== 1'b0 || bus64.out_tag !== TAG_W'(i + 4)) begin
        errs++;
        $display("FAIL directed_%0d: got vld=%b/%b imm=%h/%h tag=%h want imm=%h/%h tag=%h",
                 i, bus32.out_valid, bus64.out_valid, bus32.immext, bus64.immext,
                 bus64.out_tag, e_t[i][31:0], e_t[i], TAG_W'(i + 4));
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'd0; instr = 25'($urandom);
    in_tag = 5'd1;
    cycle();
    vectors++;
    if (bus32.in_ready !== 1'b1 || bus64.out_valid !== 1'b1 || bus64.out_tag !== 5'd1) begin
      errs++;
      $display("FAIL bp_first: got rdy=%b vld=%b tag=%0d want 1 1 1",
               bus32.in_ready, bus64.out_valid, bus64.out_tag);
    end
    in_tag = 5'd2; immsrc = 3'd1; instr = 25'($urandom);
    cycle();
    vectors++;
    if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0 || bus32.out_tag !== 5'd1) begin
      errs++;
      $display("FAIL bp_full: got rdy=%b/%b tag=%0d want rdy=0 tag=1",
               bus32.in_ready, bus64.in_ready, bus32.out_tag);
    end
    in_tag = 5'd3; immsrc = 3'd3; instr = 25'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (bus64.in_ready !== 1'b0 || bus64.out_valid !== 1'b1 || bus64.out_tag !== 5'd1 ||
          bus64.immext !== mq[0].imm || bus32.immext !== mq[0].imm[31:0]) begin
        errs++;
        $display("FAIL bp_stall_%0d: got rdy=%b vld=%b tag=%0d imm=%h want 0 1 1 %h",
                 i, bus64.in_ready, bus64.out_valid, bus64.out_tag, bus64.immext, mq[0].imm);
      end
    end
    out_ready = 1'b1;
    cycle();
    vectors++;
    if (bus64.out_tag !== 5'd2 || bus32.in_ready !== 1'b1 || bus64.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL bp_release: got tag=%0d rdy=%b vld=%b want tag=2 rdy=1 vld=1",
               bus64.out_tag, bus32.in_ready, bus64.out_valid);
    end
    cycle();
    in_valid = 1'b0;
    vectors++;
    if (bus64.out_tag !== 5'd3 || bus32.out_tag !== 5'd3 || bus64.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL bp_third: got tag=%0d/%0d vld=%b want tag=3 vld=1",
               bus32.out_tag, bus64.out_tag, bus64.out_valid);
    end
    cycle();
    vectors++;
    if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_drain: got vld=%b/%b want 0", bus32.out_valid, bus64.out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; instr = 25'($urandom); immsrc = (i % 2 == 0) ? 3'd6 : 3'd7;
      in_tag = TAG_W'(i);
      cycle();
      vectors++;
      if (bus32.out_illegal !== 1'b1 || bus64.out_illegal !== 1'b1 ||
          bus32.immext !== 32'h0 || bus64.immext !== 64'h0 ||
          bus64.illegal_cnt !== cnt64[7:0]) begin
        errs++;
        $display("FAIL illegal_%0d: got ill=%b/%b imm=%h/%h cnt=%0d want ill=1 imm=0 cnt=%0d",
                 i, bus32.out_illegal, bus64.out_illegal, bus32.immext, bus64.immext,
                 bus64.illegal_cnt, cnt64);
      end
    end
    in_valid = 1'b0;
    cycle();
    vectors++;
    if (bus32.illegal_cnt !== 2'd3) begin
      errs++;
      $display("FAIL illegal_sat: got cnt=%0d want 3", bus32.illegal_cnt);
    end
  endtask

  task automatic test_zimm();
    logic [24:0] f;
    logic [63:0] e_imm;
    logic        e_ill;
    f = 25'($urandom);
    f[12:8] = 5'b10101;
`ifdef IMM_ZIMM_EN
    e_imm = 64'h15; e_ill = 1'b0;
`else
    e_imm = 64'h0;  e_ill = 1'b1;
`endif
    out_ready = 1'b1; in_valid = 1'b1; instr = f; immsrc = 3'd5; in_tag = 5'd9;
    cycle();
    in_valid = 1'b0;
    vectors++;
    if (bus32.immext !== e_imm[31:0] || bus64.immext !== e_imm ||
        bus32.out_illegal !== e_ill || bus64.out_illegal !== e_ill) begin
      errs++;
      $display("FAIL zimm: got imm=%h/%h ill=%b/%b want imm=%h ill=%b",
               bus32.immext, bus64.immext, bus32.out_illegal, bus64.out_illegal, e_imm, e_ill);
    end
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'd0;
    for (int i = 0; i < 2; i++) begin
      instr = 25'($urandom); in_tag = TAG_W'(20 + i);
      cycle();
    end
    vectors++;
    if (bus64.in_ready !== 1'b0 || bus64.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL flush_fill: got rdy=%b vld=%b want 0 1", bus64.in_ready, bus64.out_valid);
    end
    flush = 1'b1; in_tag = 5'd22; immsrc = 3'd6;
    cycle();
    flush = 1'b0;
    vectors++;
    if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0 ||
        bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1 ||
        bus64.illegal_cnt !== cnt64[7:0]) begin
      errs++;
      $display("FAIL flush_two: got vld=%b/%b rdy=%b/%b cnt=%0d want vld=0 rdy=1 cnt=%0d",
               bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready,
               bus64.illegal_cnt, cnt64);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL flush_dropped_%0d: got vld=%b/%b want 0", i, bus32.out_valid, bus64.out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic e_rdy;
    logic e_vld;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr     = 25'($urandom);
      immsrc    = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      cycle();
      e_rdy = (mq.size() < 2);
      e_vld = (mq.size() > 0);
      vectors++;
      if (bus32.in_ready !== e_rdy || bus64.in_ready !== e_rdy ||
          bus32.out_valid !== e_vld || bus64.out_valid !== e_vld) begin
        errs++;
        $display("FAIL rnd_hs cyc %0d: got rdy=%b/%b vld=%b/%b want rdy=%b vld=%b",
                 n, bus32.in_ready, bus64.in_ready, bus32.out_valid, bus64.out_valid, e_rdy, e_vld);
      end
      vectors++;
      if (bus32.illegal_cnt !== cnt32[1:0] || bus64.illegal_cnt !== cnt64[7:0]) begin
        errs++;
        $display("FAIL rnd_cnt cyc %0d: got %0d/%0d want %0d/%0d",
                 n, bus32.illegal_cnt, bus64.illegal_cnt, cnt32, cnt64);
      end
      if (e_vld) begin
        vectors++;
        if (bus32.immext !== mq[0].imm[31:0] || bus64.immext !== mq[0].imm ||
            bus32.out_tag !== mq[0].tag || bus64.out_tag !== mq[0].tag ||
            bus32.out_illegal !== mq[0].ill || bus64.out_illegal !== mq[0].ill) begin
          errs++;
          $display("FAIL rnd_data cyc %0d: got imm=%h/%h tag=%h/%h ill=%b/%b want imm=%h tag=%h ill=%b",
                   n, bus32.immext, bus64.immext, bus32.out_tag, bus64.out_tag,
                   bus32.out_illegal, bus64.out_illegal, mq[0].imm, mq[0].tag, mq[0].ill);
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'd7; instr = 25'($urandom); in_tag = 5'd17;
    cycle();
    immsrc = 3'd4; instr = 25'h1FFFFFF;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0 || bus32.immext !== 32'h0 ||
        bus64.immext !== 64'h0 || bus32.out_tag !== '0 || bus64.out_tag !== '0 ||
        bus32.out_illegal !== 1'b0 || bus64.out_illegal !== 1'b0 ||
        bus32.illegal_cnt !== 2'd0 || bus64.illegal_cnt !== 8'd0) begin
      errs++;
      $display("FAIL async_reset: got vld=%b/%b imm=%h/%h tag=%h/%h ill=%b/%b cnt=%0d/%0d want all zero",
               bus32.out_valid, bus64.out_valid, bus32.immext, bus64.immext, bus32.out_tag,
               bus64.out_tag, bus32.out_illegal, bus64.out_illegal, bus32.illegal_cnt, bus64.illegal_cnt);
    end
    mq.delete(); cnt32 = 0; cnt64 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    vectors++;
    if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_release: got rdy=%b/%b vld=%b want rdy=1 vld=0",
               bus32.in_ready, bus64.in_ready, bus64.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal();
    test_zimm();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
